// File: rtl/prbs_pkg.sv
// Shared types and helpers for the PRBS generator and checker.
package prbs_pkg;

   typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} chk_state_t;

   localparam int MAX_W = 64;

   typedef struct packed {
      logic [MAX_W-1:0] next_state;
      logic [MAX_W-1:0] beat;
   } unroll_t;

   // Advances a Fibonacci LFSR of 'size' bits by 'w' steps; first output bit lands in beat[w-1].
   function automatic unroll_t prbs_unroll(input logic [63:0] state, input logic [63:0] poly,
                                           input int size, input int w);
      unroll_t r;
      logic [63:0] s;
      logic [63:0] mask;
      logic b;
      mask = (size >= 64) ? {64{1'b1}} : ((64'd1 << size) - 64'd1);
      s = state & mask;
      r.beat = '0;
      for (int i = 0; i < MAX_W; i++) begin
         if (i < w) begin
            b = ^(s & poly);
            s = ((s << 1) | {63'd0, b}) & mask;
            r.beat = {r.beat[62:0], b};
         end
      end
      r.next_state = s;
      return r;
   endfunction

   function automatic logic [6:0] popcount(input logic [63:0] v);
      logic [6:0] n;
      n = '0;
      for (int i = 0; i < 64; i++) begin
         n = n + {6'd0, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS checker: locks onto the incoming stream, then counts bit errors
// against its own free-running prediction.
module prbs_checker
   import prbs_pkg::*;
#(
   parameter int SIZE = 7,
   parameter logic [SIZE-1:0] POLY = 7'h60,
   parameter int W = 8,
   parameter int LOCK_CNT = 4,
   parameter int UNLOCK_CNT = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             valid,
   input  logic [W-1:0]     data,
   input  logic             clr_count,
   output logic             locked,
   output logic [CNT_W-1:0] err_count
);

   localparam int FILL_W = $clog2(SIZE + W + 1);
   localparam int GOOD_W = $clog2(LOCK_CNT + 1);
   localparam int BAD_W  = $clog2(UNLOCK_CNT + 1);

   chk_state_t        state;
   logic [SIZE-1:0]   hist;
   logic [FILL_W-1:0] fill;
   logic [GOOD_W-1:0] good;
   logic [BAD_W-1:0]  bad;

   unroll_t           u;
   logic              u_unused;
   logic [W-1:0]      pred;
   logic [SIZE-1:0]   hist_pred;
   logic [SIZE+W-1:0] shifted;
   logic [6:0]        errs;
   logic [FILL_W-1:0] fill_sum;
   logic [GOOD_W-1:0] good_inc;
   logic [BAD_W-1:0]  bad_inc;
   logic [CNT_W:0]    sum;
   logic [CNT_W-1:0]  count_sat;
   logic              clean;

   assign u         = prbs_unroll(64'(hist), 64'(POLY), SIZE, W);
   assign u_unused  = ^u;
   assign pred      = W'(u.beat);
   assign hist_pred = SIZE'(u.next_state);
   assign shifted   = {hist, data};
   assign errs      = popcount(64'(pred ^ data));
   assign fill_sum  = fill + FILL_W'(W);
   assign good_inc  = good + GOOD_W'(1);
   assign bad_inc   = bad + BAD_W'(1);
   assign sum       = {1'b0, err_count} + (CNT_W+1)'(errs);
   assign count_sat = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
   assign clean     = (fill == FILL_W'(SIZE)) && (errs == '0);

   // While locked the history follows the prediction, so a received error never propagates.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= SEARCH;
         hist      <= '0;
         fill      <= '0;
         good      <= '0;
         bad       <= '0;
         locked    <= 1'b0;
         err_count <= '0;
      end else begin
         if (valid) begin
            case (state)
               SEARCH: begin
                  hist <= shifted[SIZE-1:0];
                  fill <= (fill_sum > FILL_W'(SIZE)) ? FILL_W'(SIZE) : fill_sum;
                  if (!clean) begin
                     good <= '0;
                  end else if (good_inc == GOOD_W'(LOCK_CNT)) begin
                     state  <= LOCKED;
                     locked <= 1'b1;
                     good   <= '0;
                     bad    <= '0;
                  end else begin
                     good <= good_inc;
                  end
               end
               LOCKED: begin
                  hist <= hist_pred;
                  if (errs == '0) begin
                     bad <= '0;
                  end else if (bad_inc == BAD_W'(UNLOCK_CNT)) begin
                     state  <= SEARCH;
                     locked <= 1'b0;
                     fill   <= '0;
                     good   <= '0;
                     bad    <= '0;
                  end else begin
                     bad <= bad_inc;
                  end
               end
            endcase
         end
         if (clr_count) begin
            err_count <= '0;
         end else if (valid && state == LOCKED) begin
            err_count <= count_sat;
         end
      end
   end

endmodule

// File: rtl/prbs_gen_check.sv
// Parallel PRBS pattern source with seed load and one-shot error injection, paired with a
// self-synchronising checker for loopback bit-error measurement.
module prbs_gen_check
   import prbs_pkg::*;
#(
   parameter int SIZE = 7,
   parameter logic [SIZE-1:0] POLY = 7'h60,
   parameter int W = 8,
   parameter int LOCK_CNT = 4,
   parameter int UNLOCK_CNT = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             seed_load,
   input  logic [SIZE-1:0]  seed_value,
   input  logic             inj_err,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_data,
   input  logic             chk_valid,
   input  logic [W-1:0]     chk_data,
   input  logic             clr_count,
   output logic             chk_locked,
   output logic [CNT_W-1:0] chk_err_count
);

   logic [SIZE-1:0] state;
   logic            inj_pend;
   logic [SIZE-1:0] seed_fix;
   logic [SIZE-1:0] src;
   unroll_t         gen_u;
   logic            gen_unused;
   logic            transfer;
   logic            load;

   // An all-zero seed would lock the LFSR, so it is replaced by all-ones.
   assign seed_fix   = (seed_value == '0) ? {SIZE{1'b1}} : seed_value;
   assign src        = seed_load ? seed_fix : state;
   assign gen_u      = prbs_unroll(64'(src), 64'(POLY), SIZE, W);
   assign gen_unused = ^gen_u;
   assign transfer   = out_valid & out_ready;
   assign load       = en & (~out_valid | transfer);

   // state always sits just past the beat held in out_data; a pending beat is never retracted.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= {SIZE{1'b1}};
         out_valid <= 1'b0;
         out_data  <= '0;
         inj_pend  <= 1'b0;
      end else begin
         out_valid <= en | (out_valid & ~out_ready);
         if (load) begin
            out_data <= W'(gen_u.beat) ^ W'(inj_pend);
            state    <= SIZE'(gen_u.next_state);
         end else if (seed_load) begin
            state <= seed_fix;
         end
         if (load && inj_pend) begin
            inj_pend <= 1'b0;
         end else if (inj_err) begin
            inj_pend <= 1'b1;
         end
      end
   end

   prbs_checker #(
      .SIZE       (SIZE),
      .POLY       (POLY),
      .W          (W),
      .LOCK_CNT   (LOCK_CNT),
      .UNLOCK_CNT (UNLOCK_CNT),
      .CNT_W      (CNT_W)
   ) u_checker (
      .clk       (clk),
      .reset     (reset),
      .valid     (chk_valid),
      .data      (chk_data),
      .clr_count (clr_count),
      .locked    (chk_locked),
      .err_count (chk_err_count)
   );

endmodule

// File: tb/tb_prbs_gen_check.sv
// Directed bench for prbs_gen_check: generator beats, stalls, seeding, injection and checker lock/count.
module tb_prbs_gen_check;

   logic        clk = 1'b0;
   logic        reset;
   logic        en;
   logic        seed_load;
   logic [6:0]  seed_value;
   logic        inj_err;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic        chk_valid;
   logic [7:0]  chk_data;
   logic        clr_count;
   logic        chk_locked;
   logic [15:0] chk_err_count;

   logic        loop_mode;
   logic        tb_chk_valid;
   logic [7:0]  tb_chk_data;
   logic [6:0]  model_s;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   assign chk_valid = loop_mode ? (out_valid & out_ready) : tb_chk_valid;
   assign chk_data  = loop_mode ? out_data : tb_chk_data;

   prbs_gen_check dut (
      .clk           (clk),
      .reset         (reset),
      .en            (en),
      .seed_load     (seed_load),
      .seed_value    (seed_value),
      .inj_err       (inj_err),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .chk_valid     (chk_valid),
      .chk_data      (chk_data),
      .clr_count     (clr_count),
      .chk_locked    (chk_locked),
      .chk_err_count (chk_err_count)
   );

   task automatic apply_stimulus(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Serial PRBS7 reference (x^7+x^6+1) producing one 8-bit beat, oldest bit in the MSB.
   task automatic next_model_beat(output logic [7:0] beat);
      logic b;
      beat = '0;
      for (int i = 0; i < 8; i++) begin
         b = model_s[6] ^ model_s[5];
         model_s = {model_s[5:0], b};
         beat = {beat[6:0], b};
      end
   endtask

   task automatic feed(input logic [7:0] flip);
      logic [7:0] b;
      next_model_beat(b);
      tb_chk_data = b ^ flip;
      apply_stimulus(1);
   endtask

   initial begin
      reset = 1'b1; en = 1'b0; seed_load = 1'b0; seed_value = '0; inj_err = 1'b0;
      out_ready = 1'b0; clr_count = 1'b0; loop_mode = 1'b0; tb_chk_valid = 1'b0;
      tb_chk_data = '0; model_s = 7'h7F;

      apply_stimulus(1);
      check_output("rst_valid", out_valid, 1'b0);
      check_output("rst_data", out_data, 8'h00);
      check_output("rst_locked", chk_locked, 1'b0);
      check_output("rst_count", chk_err_count, 16'h0000);

      // Free-running beats from the all-ones reset state.
      reset = 1'b0; en = 1'b1; out_ready = 1'b1;
      apply_stimulus(1);
      check_output("beat1_valid", out_valid, 1'b1);
      check_output("beat1", out_data, 8'h02);
      apply_stimulus(1);
      check_output("beat2", out_data, 8'h0C);
      apply_stimulus(1);
      check_output("beat3", out_data, 8'h28);
      apply_stimulus(1);
      check_output("beat4", out_data, 8'hF2);
      apply_stimulus(124);
      check_output("beat128_wrap", out_data, 8'h02);
      apply_stimulus(1);
      check_output("beat129", out_data, 8'h0C);
      apply_stimulus(1);
      check_output("beat130", out_data, 8'h28);

      // Stall for five cycles, dropping en part way through.
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i == 2) en = 1'b0;
         apply_stimulus(1);
         check_output("stall_valid", out_valid, 1'b1);
         check_output("stall_data", out_data, 8'h28);
      end
      out_ready = 1'b1;
      apply_stimulus(1);
      check_output("drain_valid", out_valid, 1'b0);
      apply_stimulus(1);
      check_output("idle_valid", out_valid, 1'b0);
      en = 1'b1;
      apply_stimulus(1);
      check_output("resume_valid", out_valid, 1'b1);
      check_output("resume_data", out_data, 8'hF2);

      // Loopback lock.
      loop_mode = 1'b1;
      apply_stimulus(4);
      check_output("lock_early", chk_locked, 1'b0);
      apply_stimulus(1);
      check_output("lock_now", chk_locked, 1'b1);
      check_output("lock_count", chk_err_count, 16'h0000);
      apply_stimulus(10);
      check_output("lock_clean_count", chk_err_count, 16'h0000);

      // Two-cycle inj_err pulse must corrupt exactly one bit.
      inj_err = 1'b1;
      apply_stimulus(2);
      inj_err = 1'b0;
      apply_stimulus(5);
      check_output("inj_count", chk_err_count, 16'h0001);
      check_output("inj_locked", chk_locked, 1'b1);
      apply_stimulus(10);
      check_output("inj_once", chk_err_count, 16'h0001);

      // Four garbage beats unlock; the live stream relocks.
      loop_mode = 1'b0; tb_chk_valid = 1'b1; tb_chk_data = 8'h00;
      apply_stimulus(3);
      check_output("unlock_early", chk_locked, 1'b1);
      apply_stimulus(1);
      check_output("unlock_now", chk_locked, 1'b0);
      tb_chk_valid = 1'b0; loop_mode = 1'b1;
      apply_stimulus(4);
      check_output("relock_early", chk_locked, 1'b0);
      apply_stimulus(1);
      check_output("relock_now", chk_locked, 1'b1);
      clr_count = 1'b1;
      apply_stimulus(1);
      clr_count = 1'b0;
      check_output("clr_count", chk_err_count, 16'h0000);

      // Counter saturation driven from the reference stream.
      loop_mode = 1'b0; en = 1'b0; reset = 1'b1;
      apply_stimulus(1);
      reset = 1'b0; tb_chk_valid = 1'b1; model_s = 7'h7F;
      for (int i = 0; i < 5; i++) feed(8'h00);
      check_output("sat_lock", chk_locked, 1'b1);
      for (int g = 0; g < 2730; g++) begin
         feed(8'hFF); feed(8'hFF); feed(8'hFF); feed(8'h00);
      end
      feed(8'hFF); feed(8'h3F); feed(8'h00);
      check_output("sat_fffe", chk_err_count, 16'hFFFE);
      check_output("sat_locked", chk_locked, 1'b1);
      feed(8'h07);
      check_output("sat_ffff", chk_err_count, 16'hFFFF);
      feed(8'h01);
      check_output("sat_hold", chk_err_count, 16'hFFFF);
      clr_count = 1'b1;
      feed(8'h01);
      clr_count = 1'b0;
      check_output("clr_wins", chk_err_count, 16'h0000);
      feed(8'h00);
      for (int i = 0; i < 4; i++) feed(8'hFF);
      check_output("drop_locked", chk_locked, 1'b0);
      check_output("drop_count", chk_err_count, 16'd32);
      for (int i = 0; i < 3; i++) feed(8'hFF);
      check_output("search_frozen", chk_err_count, 16'd32);
      tb_chk_valid = 1'b0;

      // Seeding, including the all-zero replacement and a seed during a stall.
      en = 1'b1; out_ready = 1'b1;
      apply_stimulus(1);
      check_output("seed_pre1", out_data, 8'h02);
      apply_stimulus(1);
      check_output("seed_pre2", out_data, 8'h0C);
      seed_load = 1'b1; seed_value = 7'h00;
      apply_stimulus(1);
      check_output("seed_zero", out_data, 8'h02);
      seed_load = 1'b0;
      apply_stimulus(1);
      check_output("seed_zero_next", out_data, 8'h0C);
      seed_load = 1'b1; seed_value = 7'h02;
      apply_stimulus(1);
      check_output("seed_02", out_data, 8'h0C);
      seed_load = 1'b0;
      apply_stimulus(1);
      check_output("seed_02_next", out_data, 8'h28);
      out_ready = 1'b0;
      apply_stimulus(1);
      seed_load = 1'b1; seed_value = 7'h28;
      apply_stimulus(1);
      seed_load = 1'b0;
      check_output("seed_stall_kept", out_data, 8'h28);
      check_output("seed_stall_valid", out_valid, 1'b1);
      out_ready = 1'b1;
      apply_stimulus(1);
      check_output("seed_stall_next", out_data, 8'hF2);

      // Asynchronous reset between clock edges while beats flow.
      apply_stimulus(3);
      #2 reset = 1'b1;
      #1;
      check_output("arst_valid", out_valid, 1'b0);
      check_output("arst_data", out_data, 8'h00);
      check_output("arst_locked", chk_locked, 1'b0);
      check_output("arst_count", chk_err_count, 16'h0000);
      apply_stimulus(1);
      reset = 1'b0;
      apply_stimulus(1);
      check_output("arst_first_beat", out_data, 8'h02);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
